// File: rtl/wam_ctl_if.sv
// Bus bundle for the Whac-A-Mole session controller: player/generator inputs
// and registered session outputs. clk/clr stay plain ports on the controller.
interface wam_ctl_if;
  logic       tick;
  logic       start;
  logic [7:0] btn;
  logic [7:0] holes;
  logic [7:0] hit;
  logic       gen_clr;
  logic       lvl_up;
  logic [7:0] score;
  logic [6:0] time_left;
  logic [1:0] state;
  logic       game_over;

  modport master (
    output tick, start, btn, holes,
    input  hit, gen_clr, lvl_up, score, time_left, state, game_over
  );

  modport slave (
    input  tick, start, btn, holes,
    output hit, gen_clr, lvl_up, score, time_left, state, game_over
  );
endinterface

// File: rtl/wam_ctl.sv
// Whac-A-Mole round sequencer: countdown, play, game over, scoring and level-up.
// Optional macro WAM_MISS_PENALTY_EN: each miss during play costs one point.
module wam_ctl #(
  parameter int GAME_SEC  = 60,
  parameter int READY_SEC = 3,
  parameter int LVL_STEP  = 10
) (
  input logic       clk,
  input logic       clr,
  wam_ctl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READY = 2'd1,
    S_PLAY  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam logic [6:0] GAME_T  = 7'(GAME_SEC);
  localparam logic [2:0] READY_T = 3'(READY_SEC);
  localparam logic [8:0] LVL_W   = 9'(LVL_STEP);

  state_t     r_state;
  logic       r_start_d;
  logic [7:0] r_btn_d;
  logic [2:0] r_cd;
  logic [7:0] r_acc;
  logic [7:0] r_score;
  logic [6:0] r_time;
  logic [7:0] r_hit;
  logic       r_lvl;
  logic       r_gen_clr;
  logic       r_over;

  logic       w_rise_start;
  logic [7:0] w_rise_btn;
  logic [7:0] w_hit_bits;
  logic [3:0] w_nh;
  logic [8:0] w_acc_sum;
  logic [8:0] w_acc_wrap;
  logic [7:0] w_score_nxt;
`ifdef WAM_MISS_PENALTY_EN
  logic [7:0]        w_miss_bits;
  logic [3:0]        w_nm;
  logic signed [9:0] w_score_s;
`else
  logic [8:0]        w_score_sum;
`endif

  always_comb begin
    w_rise_start = bus.start & ~r_start_d;
    w_rise_btn   = bus.btn & ~r_btn_d;
    w_hit_bits   = w_rise_btn & bus.holes;
    w_nh = '0;
    for (int unsigned i = 0; i < 8; i++) w_nh = w_nh + {3'b000, w_hit_bits[i]};
    w_acc_sum  = {1'b0, r_acc} + {5'b00000, w_nh};
    w_acc_wrap = w_acc_sum - LVL_W;
`ifdef WAM_MISS_PENALTY_EN
    w_miss_bits = w_rise_btn & ~bus.holes;
    w_nm = '0;
    for (int unsigned i = 0; i < 8; i++) w_nm = w_nm + {3'b000, w_miss_bits[i]};
    // 10-bit signed sum spans -8..263: sign bit means clamp low, bit 8 clamp high
    w_score_s = $signed({2'b00, r_score}) + $signed({6'b000000, w_nh})
              - $signed({6'b000000, w_nm});
    if (w_score_s[9])      w_score_nxt = '0;
    else if (w_score_s[8]) w_score_nxt = '1;
    else                   w_score_nxt = w_score_s[7:0];
`else
    w_score_sum = {1'b0, r_score} + {5'b00000, w_nh};
    w_score_nxt = w_score_sum[8] ? '1 : w_score_sum[7:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_start_d <= bus.start;
      r_btn_d   <= bus.btn;
      r_cd      <= READY_T;
      r_acc     <= '0;
      r_score   <= '0;
      r_time    <= GAME_T;
      r_hit     <= '0;
      r_lvl     <= 1'b0;
      r_gen_clr <= 1'b1;
      r_over    <= 1'b0;
    end else begin
      r_start_d <= bus.start;
      r_btn_d   <= bus.btn;
      r_hit     <= '0;
      r_lvl     <= 1'b0;
      case (r_state)
        S_IDLE, S_OVER: begin
          if (w_rise_start) begin
            r_state   <= S_READY;
            r_cd      <= READY_T;
            r_score   <= '0;
            r_time    <= GAME_T;
            r_acc     <= '0;
            r_gen_clr <= 1'b1;
            r_over    <= 1'b0;
          end
        end
        S_READY: begin
          if (bus.tick) begin
            if (r_cd == 3'd1) begin
              r_state   <= S_PLAY;
              r_gen_clr <= 1'b0;
            end else begin
              r_cd <= r_cd - 3'd1;
            end
          end
        end
        S_PLAY: begin
          // hits are scored even on the final tick of the round
          r_hit   <= w_hit_bits;
          r_score <= w_score_nxt;
          if (w_acc_sum >= LVL_W) begin
            r_acc <= w_acc_wrap[7:0];
            r_lvl <= 1'b1;
          end else begin
            r_acc <= w_acc_sum[7:0];
          end
          if (bus.tick) begin
            r_time <= r_time - 7'd1;
            if (r_time == 7'd1) begin
              r_state   <= S_OVER;
              r_gen_clr <= 1'b1;
              r_over    <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.hit       = r_hit;
  assign bus.gen_clr   = r_gen_clr;
  assign bus.lvl_up    = r_lvl;
  assign bus.score     = r_score;
  assign bus.time_left = r_time;
  assign bus.state     = r_state;
  assign bus.game_over = r_over;

endmodule

// File: tb/tb_wam_ctl.sv
// Self-checking bench for wam_ctl: directed scenarios plus randomized play
// compared against a round-level behavioural model.
module tb_wam_ctl;
  localparam int GAME = 60;
  localparam int RDY  = 3;
  localparam int LVL  = 10;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  wam_ctl_if bus ();

  wam_ctl #(.GAME_SEC(GAME), .READY_SEC(RDY), .LVL_STEP(LVL)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // behavioural model: 0 idle, 1 countdown, 2 play, 3 over
  int         m_state, m_score, m_time, m_acc, m_cd;
  logic [7:0] m_hit;
  bit         m_lvl;
  logic [7:0] m_prevb;
  bit         m_prevs;

  task automatic model_step(input bit c, input bit t, input bit s,
                            input logic [7:0] b, input logic [7:0] h);
    logic [7:0] rb;
    bit rs;
    int nh, nm, sc;
    rb = b & ~m_prevb;
    rs = s & ~m_prevs;
    m_prevb = b;
    m_prevs = s;
    m_hit = 8'h00;
    m_lvl = 1'b0;
    if (c) begin
      m_state = 0; m_score = 0; m_time = GAME; m_acc = 0; m_cd = RDY;
    end else if (m_state == 0 || m_state == 3) begin
      if (rs) begin
        m_state = 1; m_cd = RDY; m_score = 0; m_time = GAME; m_acc = 0;
      end
    end else if (m_state == 1) begin
      if (t) begin
        if (m_cd == 1) m_state = 2;
        else m_cd = m_cd - 1;
      end
    end else begin
      nh = $countones(rb & h);
      nm = $countones(rb & ~h);
      m_hit = rb & h;
`ifdef WAM_MISS_PENALTY_EN
      sc = m_score + nh - nm;
`else
      sc = m_score + nh;
      nm = 0;
`endif
      if (sc < 0) sc = 0;
      if (sc > 255) sc = 255;
      m_score = sc;
      m_acc = m_acc + nh;
      if (m_acc >= LVL) begin
        m_acc = m_acc - LVL;
        m_lvl = 1'b1;
      end
      if (t) begin
        m_time = m_time - 1;
        if (m_time == 0) m_state = 3;
      end
    end
  endtask

  task automatic drive(input bit c, input bit t, input bit s,
                       input logic [7:0] b, input logic [7:0] h);
    clr = c; bus.tick = t; bus.start = s; bus.btn = b; bus.holes = h;
    model_step(c, t, s, b, h);
    @(posedge clk);
    #1;
  endtask

  task automatic go_play();
    drive(1, 0, 0, 8'h00, 8'h00);
    drive(0, 0, 1, 8'h00, 8'h00);
    for (int i = 0; i < RDY; i++) drive(0, 1, 0, 8'h00, 8'h00);
  endtask

  task automatic test_reset();
    drive(1, 0, 1, 8'hA5, 8'hFF);
    n_cmp++; if (bus.state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", bus.state); end
    n_cmp++; if (bus.score !== 8'd0) begin n_err++; $display("FAIL rst_score: got %0d want 0", bus.score); end
    n_cmp++; if (bus.time_left !== 7'd60) begin n_err++; $display("FAIL rst_time: got %0d want 60", bus.time_left); end
    n_cmp++; if (bus.hit !== 8'h00 || bus.lvl_up !== 1'b0) begin n_err++; $display("FAIL rst_pulses: got hit=%h lvl=%b want 00/0", bus.hit, bus.lvl_up); end
    n_cmp++; if (bus.gen_clr !== 1'b1 || bus.game_over !== 1'b0) begin n_err++; $display("FAIL rst_flags: got gen_clr=%b over=%b want 1/0", bus.gen_clr, bus.game_over); end
    // start held through reset must not look like a fresh edge
    drive(0, 0, 1, 8'hA5, 8'hFF);
    n_cmp++; if (bus.state !== 2'd0) begin n_err++; $display("FAIL rst_no_edge: got state %0d want 0", bus.state); end
  endtask

  task automatic test_start_countdown();
    drive(0, 0, 0, 8'h00, 8'h00);
    drive(0, 0, 1, 8'h00, 8'h00);
    n_cmp++; if (bus.state !== 2'd1 || bus.gen_clr !== 1'b1) begin n_err++; $display("FAIL cd_enter: got state=%0d gen_clr=%b want 1/1", bus.state, bus.gen_clr); end
    drive(0, 1, 1, 8'hFF, 8'hFF);
    n_cmp++; if (bus.state !== 2'd1 || bus.hit !== 8'h00) begin n_err++; $display("FAIL cd_tick1: got state=%0d hit=%h want 1/00", bus.state, bus.hit); end
    drive(0, 0, 0, 8'h00, 8'h00);
    drive(0, 1, 0, 8'h00, 8'h00);
    n_cmp++; if (bus.state !== 2'd1) begin n_err++; $display("FAIL cd_tick2: got state %0d want 1", bus.state); end
    drive(0, 1, 0, 8'h00, 8'h00);
    n_cmp++; if (bus.state !== 2'd2 || bus.gen_clr !== 1'b0 || bus.time_left !== 7'd60) begin
      n_err++; $display("FAIL cd_play: got state=%0d gen_clr=%b time=%0d want 2/0/60", bus.state, bus.gen_clr, bus.time_left); end
  endtask

  task automatic test_hit_qual();
    drive(0, 0, 0, 8'h07, 8'h05);
    n_cmp++; if (bus.hit !== 8'h05 || bus.score !== 8'd2) begin n_err++; $display("FAIL hq_hit: got hit=%h score=%0d want 05/2", bus.hit, bus.score); end
    drive(0, 0, 0, 8'h07, 8'h05);
    n_cmp++; if (bus.hit !== 8'h00 || bus.score !== 8'd2) begin n_err++; $display("FAIL hq_hold: got hit=%h score=%0d want 00/2", bus.hit, bus.score); end
    drive(0, 0, 0, 8'h00, 8'h05);
  endtask

  task automatic test_level_up();
    go_play();
    for (int k = 1; k <= 10; k++) begin
      drive(0, 0, 0, 8'h01, 8'h01);
      n_cmp++; if (bus.lvl_up !== (k == 10)) begin n_err++; $display("FAIL lvl_single%0d: got %b want %b", k, bus.lvl_up, (k == 10)); end
      drive(0, 0, 0, 8'h00, 8'h01);
      n_cmp++; if (bus.lvl_up !== 1'b0) begin n_err++; $display("FAIL lvl_gap%0d: got %b want 0", k, bus.lvl_up); end
    end
    for (int k = 1; k <= 9; k++) begin
      drive(0, 0, 0, 8'h01, 8'h01);
      drive(0, 0, 0, 8'h00, 8'h01);
    end
    drive(0, 0, 0, 8'h03, 8'h03);
    n_cmp++; if (bus.lvl_up !== 1'b1 || bus.hit !== 8'h03) begin n_err++; $display("FAIL lvl_double: got lvl=%b hit=%h want 1/03", bus.lvl_up, bus.hit); end
    drive(0, 0, 0, 8'h00, 8'h03);
    // residue of 1 carries: the 9th further hit reaches the step
    for (int k = 1; k <= 9; k++) begin
      drive(0, 0, 0, 8'h01, 8'h01);
      n_cmp++; if (bus.lvl_up !== (k == 9)) begin n_err++; $display("FAIL lvl_carry%0d: got %b want %b", k, bus.lvl_up, (k == 9)); end
      drive(0, 0, 0, 8'h00, 8'h01);
    end
  endtask

  task automatic test_round_end();
    go_play();
    for (int k = 0; k < GAME - 1; k++) drive(0, 1, 0, 8'h00, 8'h00);
    n_cmp++; if (bus.state !== 2'd2 || bus.time_left !== 7'd1) begin n_err++; $display("FAIL end_pre: got state=%0d time=%0d want 2/1", bus.state, bus.time_left); end
    drive(0, 1, 0, 8'h01, 8'h01);
    n_cmp++; if (bus.state !== 2'd3 || bus.time_left !== 7'd0 || bus.game_over !== 1'b1 || bus.gen_clr !== 1'b1) begin
      n_err++; $display("FAIL end_over: got state=%0d time=%0d over=%b gen_clr=%b want 3/0/1/1", bus.state, bus.time_left, bus.game_over, bus.gen_clr); end
    n_cmp++; if (bus.hit !== 8'h01 || bus.score !== 8'd1) begin n_err++; $display("FAIL end_lasthit: got hit=%h score=%0d want 01/1", bus.hit, bus.score); end
    drive(0, 0, 0, 8'h00, 8'hFF);
    drive(0, 1, 0, 8'hFF, 8'hFF);
    n_cmp++; if (bus.hit !== 8'h00 || bus.score !== 8'd1 || bus.time_left !== 7'd0) begin
      n_err++; $display("FAIL end_frozen: got hit=%h score=%0d time=%0d want 00/1/0", bus.hit, bus.score, bus.time_left); end
    drive(0, 0, 1, 8'h00, 8'h00);
    n_cmp++; if (bus.state !== 2'd1 || bus.score !== 8'd0 || bus.time_left !== 7'd60 || bus.game_over !== 1'b0) begin
      n_err++; $display("FAIL end_restart: got state=%0d score=%0d time=%0d over=%b want 1/0/60/0", bus.state, bus.score, bus.time_left, bus.game_over); end
  endtask

  task automatic test_mid_reset();
    go_play();
    drive(0, 0, 0, 8'hFF, 8'hFF);
    drive(0, 0, 0, 8'h00, 8'hFF);
    drive(0, 0, 0, 8'hFF, 8'hFF);
    drive(0, 0, 0, 8'h00, 8'hFF);
    drive(0, 0, 0, 8'h01, 8'h01);
    n_cmp++; if (bus.score !== 8'd17) begin n_err++; $display("FAIL mid_score: got %0d want 17", bus.score); end
    drive(1, 1, 0, 8'h02, 8'h02);
    n_cmp++; if (bus.state !== 2'd0 || bus.score !== 8'd0 || bus.gen_clr !== 1'b1 || bus.hit !== 8'h00 || bus.time_left !== 7'd60) begin
      n_err++; $display("FAIL mid_reset: got state=%0d score=%0d gen_clr=%b hit=%h time=%0d want 0/0/1/00/60",
                        bus.state, bus.score, bus.gen_clr, bus.hit, bus.time_left); end
  endtask

  task automatic test_saturate();
    go_play();
    for (int k = 1; k <= 32; k++) begin
      drive(0, 0, 0, 8'hFF, 8'hFF);
      drive(0, 0, 0, 8'h00, 8'hFF);
      if (k == 31) begin
        n_cmp++; if (bus.score !== 8'd248) begin n_err++; $display("FAIL sat_pre: got %0d want 248", bus.score); end
      end
    end
    n_cmp++; if (bus.score !== 8'd255) begin n_err++; $display("FAIL sat_cap: got %0d want 255", bus.score); end
  endtask

  task automatic test_penalty();
    logic [7:0] want;
    go_play();
    drive(0, 0, 0, 8'h01, 8'h00);
    n_cmp++; if (bus.score !== 8'd0 || bus.hit !== 8'h00) begin n_err++; $display("FAIL pen_floor: got score=%0d hit=%h want 0/00", bus.score, bus.hit); end
    drive(0, 0, 0, 8'h00, 8'h00);
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 8'h10, 8'h10);
      drive(0, 0, 0, 8'h00, 8'h10);
    end
    n_cmp++; if (bus.score !== 8'd5) begin n_err++; $display("FAIL pen_five: got %0d want 5", bus.score); end
`ifdef WAM_MISS_PENALTY_EN
    want = 8'd4;
`else
    want = 8'd6;
`endif
    drive(0, 0, 0, 8'h07, 8'h01);
    n_cmp++; if (bus.score !== want || bus.hit !== 8'h01) begin n_err++; $display("FAIL pen_mix: got score=%0d hit=%h want %0d/01", bus.score, bus.hit, want); end
  endtask

  task automatic test_tick_start_same();
    drive(1, 0, 0, 8'h00, 8'h00);
    drive(0, 1, 1, 8'h00, 8'h00);
    n_cmp++; if (bus.state !== 2'd1) begin n_err++; $display("FAIL ts_enter: got %0d want 1", bus.state); end
    drive(0, 1, 1, 8'h00, 8'h00);
    drive(0, 1, 1, 8'h00, 8'h00);
    n_cmp++; if (bus.state !== 2'd1) begin n_err++; $display("FAIL ts_still: got %0d want 1", bus.state); end
    drive(0, 1, 0, 8'h00, 8'h00);
    n_cmp++; if (bus.state !== 2'd2) begin n_err++; $display("FAIL ts_play: got %0d want 2", bus.state); end
  endtask

  task automatic test_random();
    logic [27:0] act, exp;
    bit c, t, s;
    logic [7:0] b, h;
    drive(1, 0, 0, 8'h00, 8'h00);
    for (int n = 0; n < 1200; n++) begin
      c = ($urandom_range(0, 399) == 0);
      t = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 11) == 0);
      b = 8'($urandom) & 8'($urandom);
      h = 8'($urandom);
      drive(c, t, s, b, h);
      exp = {2'(m_state), 8'(m_score), 7'(m_time), m_hit, m_lvl, (m_state != 2), (m_state == 3)};
      act = {bus.state, bus.score, bus.time_left, bus.hit, bus.lvl_up, bus.gen_clr, bus.game_over};
      n_cmp++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL rand%0d: got st=%0d sc=%0d t=%0d hit=%h lvl=%b gc=%b go=%b want st=%0d sc=%0d t=%0d hit=%h lvl=%b gc=%b go=%b",
                 n, act[27:26], act[25:18], act[17:11], act[10:3], act[2], act[1], act[0],
                 exp[27:26], exp[25:18], exp[17:11], exp[10:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  initial begin
    clr = 1'b1; bus.tick = 1'b0; bus.start = 1'b0; bus.btn = 8'h00; bus.holes = 8'h00;
    m_prevb = 8'h00; m_prevs = 1'b0;
    #2;
    test_reset();
    test_start_countdown();
    test_hit_qual();
    test_level_up();
    test_round_end();
    test_mid_reset();
    test_saturate();
    test_penalty();
    test_tick_start_same();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
